i2s_window_capture: RTL
=======================

# i2s_window_capture

Parametrised I2S microphone front end and sample-window buffer. It generates BCLK/LRCLK, deserialises mono or stereo two's-complement samples of configurable width, and keeps a sliding window of the last N samples per channel. Every HOP samples it presents an oldest-first window snapshot on a flat bus with a valid/ready handshake. It sits between the microphone pins and the FFT processor, replaces the fixed 16-point, 24-bit, mono, non-overlapping capture path, and adds stereo, overlap and overrun reporting.

## Interface
- SAMPLE_W, 24: sample width in bits, 8..31.
- N, 16: window depth per channel, power of 2, ≥2.
- HOP, 16: new samples between snapshots, 1..N (HOP<N gives overlap).
- CHANNELS, 1: 1 = left slot only, 2 = left+right.
- BCLK_DIV, 2: clk cycles per BCLK half-period, ≥1.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- DOUT  in  1  I2S serial data from mic.
- BCLK  out  1  I2S bit clock, registered.
- LRCLK  out  1  I2S word select, registered; 0 = left, 1 = right.
- frame_data  out  CHANNELS*N*SAMPLE_W  snapshot; channel c, sample k at [(c*N+k)*SAMPLE_W +: SAMPLE_W]; k=0 oldest.
- frame_valid  out  1  snapshot available.
- frame_ready  in  1  consumer accepts snapshot.
- overrun  out  1  one-cycle pulse when a snapshot is dropped.
- overrun_cnt  out  8  saturating count of dropped snapshots.

## Operation
- Reset values: BCLK=0, LRCLK=0, frame_data=0, frame_valid=0, overrun=0, overrun_cnt=0. Bit counter, divider, fill and hop counters and buffers all clear.
- Divider counts 0..BCLK_DIV-1. At the terminal count BCLK toggles, giving a BCLK period of 2*BCLK_DIV clk.
- Bit counter 0..63 advances on each BCLK falling edge. LRCLK = bit counter[5], giving 32 BCLK per slot.
- Sampling: DOUT is sampled in the clk cycle where BCLK goes 0→1. Slot bit positions 1..SAMPLE_W are shifted in MSB first. Position 0 (I2S one-bit delay) and positions above SAMPLE_W are ignored.
- Sample complete: on the rising edge of slot position SAMPLE_W the word is latched. One clk later it is written to that channel's circular buffer.
- Frame: one left sample when CHANNELS=1, or a left+right pair when CHANNELS=2. Fill and hop counters advance when the frame completes (right write for stereo).
- Fill saturates at N. The hop counter wraps at HOP.
- Snapshot trigger: the hop counter wraps and fill == N. The first snapshot follows exactly N frames after reset; later snapshots follow every HOP frames.
- Snapshot action: copy all N entries per channel, oldest first, into frame_data and set frame_valid.
- Handshake: frame_valid stays high, and frame_data stays stable, until a cycle with frame_valid & frame_ready. frame_valid drops the next cycle unless a new snapshot loads in that same cycle.
- Trigger while frame_valid=1 and frame_ready=0: the snapshot is dropped. frame_data is unchanged, overrun pulses, overrun_cnt increments (saturating at 255), and the hop counter still wraps.
- Trigger in the same cycle as acceptance: the new snapshot loads and frame_valid stays 1. This is not an overrun.
- DOUT is never treated as X. Unused slot bits are don't-care.

## Timing
- BCLK first rises BCLK_DIV clk after reset deasserts. LRCLK period = 128*BCLK_DIV clk.
- Latency: frame_valid rises 2 clk after the BCLK rising edge that samples the last bit (position SAMPLE_W) of the triggering sample. That is 1 clk for the buffer write plus 1 clk for the snapshot.
- overrun pulses in the same cycle frame_data would have loaded.
- Reset mid-word or mid-frame: outputs go to reset values immediately and asynchronously. The partial sample is discarded, fill restarts at 0, and the next snapshot requires N full frames.
- Buffer write pointer wraps modulo N. Snapshot ordering stays oldest-first across the wrap.

## Test plan
- Reset/clocks (BCLK_DIV=2): release reset → BCLK first high at clk 2, period 4 clk; LRCLK period 256 clk, toggles only on BCLK falling edges; all outputs 0 before the first snapshot.
- Stereo constant (CHANNELS=2, N=16, HOP=16): left 0x800001, right 0x7FFFFF → after frame 16, frame_valid=1; all 16 left words 0x800001 and all 16 right words 0x7FFFFF; frame_valid rises 2 clk after the last right LSB is sampled.
- Ordering/wrap (CHANNELS=1, N=16, HOP=16): left ramp 1,2,3,…, accept every snapshot → snapshot 1 holds k=0..15 = 1..16 and snapshot 2 holds 17..32.
- Overlap (HOP=4): same ramp → snapshot 1 holds 1..16, snapshot 2 holds 5..20, snapshot 3 holds 9..24.
- Overrun (HOP=4): hold frame_ready=0 through the second trigger → overrun pulses for 1 clk, overrun_cnt=1, frame_data still 1..16. Raise frame_ready exactly on the third trigger cycle → snapshot 9..24 loads, frame_valid stays 1, overrun_cnt stays 1.
- Reset mid-operation: assert reset at frame 10, bit 7 → all outputs 0 immediately; after release, the first snapshot follows 16 complete frames.

Source files
------------

// File: rtl/i2s_window_capture.sv
// I2S microphone front end: generates BCLK/LRCLK, deserialises mono or stereo samples
// and presents an oldest-first sliding window of the last N samples every HOP frames.
module i2s_window_capture #(
    parameter int SAMPLE_W = 24,
    parameter int N        = 16,
    parameter int HOP      = 16,
    parameter int CHANNELS = 1,
    parameter int BCLK_DIV = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            DOUT,
    output logic                            BCLK,
    output logic                            LRCLK,
    output logic [CHANNELS*N*SAMPLE_W-1:0]  frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic                            overrun,
    output logic [7:0]                      overrun_cnt
);
    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PTR_W  = $clog2(N);
    localparam int FILL_W = $clog2(N + 1);
    localparam int HOP_W  = $clog2(HOP + 1);
    localparam logic [4:0] LAST_POS = 5'(SAMPLE_W);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Circular buffer slot holding sample k (0 = oldest) of a channel, given the write pointer.
    function automatic int oldest_idx(input int ch, input int k, input logic [PTR_W-1:0] wp);
        logic [PTR_W-1:0] p;
        p = wp + PTR_W'(k);
        return ch * N + int'(p);
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             bclk_rise;
    logic             bclk_fall;
    logic [5:0]       bit_cnt;

    assign div_tc    = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_rise = div_tc & ~BCLK;
    assign bclk_fall = div_tc & BCLK;
    assign LRCLK     = bit_cnt[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            BCLK    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc)
                BCLK <= ~BCLK;
            if (bclk_fall)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Stage p0: shift in slot positions 1..SAMPLE_W on BCLK rising edges, latch the word.
    logic [4:0]                 slot_pos;
    logic                       slot_ch;
    logic                       ch_enabled;
    logic                       take_bit;
    logic [SAMPLE_W-2:0]        shift_sr;
    logic signed [SAMPLE_W-1:0] word_p0;
    logic                       vld_p0;
    logic                       ch_p0;

    assign slot_pos   = bit_cnt[4:0];
    assign slot_ch    = bit_cnt[5];
    assign ch_enabled = (CHANNELS == 2) || !slot_ch;
    assign take_bit   = bclk_rise && (slot_pos != 5'd0) && (slot_pos <= LAST_POS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_sr <= '0;
            word_p0  <= '0;
            vld_p0   <= 1'b0;
            ch_p0    <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (take_bit) begin
                shift_sr <= {shift_sr[SAMPLE_W-3:0], DOUT};
                if (slot_pos == LAST_POS) begin
                    word_p0 <= {shift_sr, DOUT};
                    vld_p0  <= ch_enabled;
                    ch_p0   <= slot_ch;
                end
            end
        end
    end

    // Stage p1: buffer write, fill/hop bookkeeping and snapshot trigger.
    logic signed [SAMPLE_W-1:0] buf_mem [CHANNELS*N];
    logic [PTR_W-1:0]           wr_ptr;
    logic [FILL_W-1:0]          fill_cnt;
    logic [HOP_W-1:0]           hop_cnt;
    logic                       frame_done;
    logic                       trig_p1;
    int                         wr_idx;

    // Stereo frames finish on the right-slot write; the shared pointer advances then.
    assign frame_done = vld_p0 && (ch_p0 == (CHANNELS == 2));

    always_comb begin
        wr_idx = int'(wr_ptr);
        if ((CHANNELS == 2) && ch_p0)
            wr_idx = N + int'(wr_ptr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS * N; i++)
                buf_mem[i] <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
            trig_p1  <= 1'b0;
        end else begin
            trig_p1 <= 1'b0;
            if (vld_p0)
                buf_mem[wr_idx] <= word_p0;
            if (frame_done) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill_cnt == FILL_W'(N - 1)) begin
                    fill_cnt <= FILL_W'(N);
                    hop_cnt  <= '0;
                    trig_p1  <= 1'b1;
                end else if (fill_cnt == FILL_W'(N)) begin
                    if (hop_cnt == HOP_W'(HOP - 1)) begin
                        hop_cnt <= '0;
                        trig_p1 <= 1'b1;
                    end else begin
                        hop_cnt <= hop_cnt + 1'b1;
                    end
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p2: snapshot load, handshake and overrun reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            overrun <= 1'b0;
            if (trig_p1 && frame_valid && !frame_ready) begin
                overrun     <= 1'b1;
                overrun_cnt <= sat_inc8(overrun_cnt);
            end else if (trig_p1) begin
                frame_valid <= 1'b1;
                for (int c = 0; c < CHANNELS; c++)
                    for (int k = 0; k < N; k++)
                        frame_data[(c*N+k)*SAMPLE_W +: SAMPLE_W] <= buf_mem[oldest_idx(c, k, wr_ptr)];
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
